// File: rtl/xor_checksum_accumulator.sv
// Per-packet XOR checksum over a framed beat stream.
// The result is presented on a valid/ready port with a saturating beat count.

module BitWiseXOR #(
    parameter int    N     = 32,
    parameter string MODEL = "Structural"
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);
    generate
        if (MODEL == "Structural") begin : g_struct
            for (genvar gi = 0; gi < N; gi++) begin : g_bit
                assign y[gi] = a[gi] ^ b[gi];
            end
        end else begin : g_behav
            assign y = a ^ b;
        end
    endgenerate
endmodule

module xor_checksum_accumulator #(
    parameter int    N     = 32,
    parameter int    CW    = 8,
    parameter string MODEL = "Structural"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_sat
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_reg, state_next;
    logic [N-1:0]  acc_reg, acc_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          out_valid_reg, out_valid_next;
    logic [N-1:0]  out_data_reg, out_data_next;
    logic [CW-1:0] out_count_reg, out_count_next;
    logic          out_sat_reg, out_sat_next;

    logic          accept;
    logic [N-1:0]  op_a;
    logic [N-1:0]  xor_y;
    logic [CW-1:0] cnt_base;
    logic [CW-1:0] cnt_inc;

    assign in_ready = !rst && !abort && (state_reg != DONE || out_ready);
    assign accept   = in_valid && in_ready;

    // A packet that is not open folds against zero, so each new packet starts clean.
    assign op_a     = (state_reg == ACCUM) ? acc_reg : '0;
    assign cnt_base = (state_reg == ACCUM) ? cnt_reg : '0;
    assign cnt_inc  = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 1'b1;

    BitWiseXOR #(
        .N     (N),
        .MODEL (MODEL)
    ) u_xor (
        .a (op_a),
        .b (in_data),
        .y (xor_y)
    );

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_count_next = out_count_reg;
        out_sat_next   = out_sat_reg;

        if (state_reg == DONE && out_ready) begin
            out_valid_next = 1'b0;
            state_next     = IDLE;
        end

        // abort forces in_ready low, so an accepted beat and an abort never coincide.
        if (accept) begin
            if (in_last) begin
                out_data_next  = xor_y;
                out_count_next = cnt_inc;
                out_sat_next   = (cnt_inc == CNT_MAX);
                out_valid_next = 1'b1;
                state_next     = DONE;
                acc_next       = '0;
                cnt_next       = '0;
            end else begin
                acc_next   = xor_y;
                cnt_next   = cnt_inc;
                state_next = ACCUM;
            end
        end else if (abort && state_reg == ACCUM) begin
            acc_next   = '0;
            cnt_next   = '0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_count_reg <= out_count_next;
            out_sat_reg   <= out_sat_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;
    assign out_sat   = out_sat_reg;
endmodule

// File: tb/tb_xor_checksum_accumulator.sv
// Scoreboard bench: two instances (CW=8 and CW=2) share one stimulus stream;
// a packet-level model predicts results and a monitor pops and compares them.

module tb_xor_checksum_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, out_sat_a;
    logic [7:0] out_data_a, out_count_a;
    logic       in_ready_b, out_valid_b, out_sat_b;
    logic [7:0] out_data_b;
    logic [1:0] out_count_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xor_checksum_accumulator #(.N(8), .CW(8), .MODEL("Structural")) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .abort(abort),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a), .out_sat(out_sat_a)
    );

    xor_checksum_accumulator #(.N(8), .CW(2), .MODEL("Behavioral")) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .abort(abort),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b), .out_sat(out_sat_b)
    );

    typedef struct packed {
        logic [7:0] d;
        int         n;
    } pkt_t;

    // Expected packets in completion order; the count is the true beat count.
    pkt_t q_a[$];
    pkt_t q_b[$];

    // Packet-level model state.
    logic       m_open = 1'b0;
    logic [7:0] m_acc = 8'h00;
    int         m_n = 0;
    logic       m_pend = 1'b0;

    function automatic int satc(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Inputs are driven just after a rising edge; checks and model updates at the falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic a, input logic r, input logic rs);
        logic exp_ready;
        pkt_t p;
        in_valid = v; in_data = d; in_last = l; abort = a; out_ready = r; rst = rs;
        @(negedge clk);
        exp_ready = !rs && !a && (!m_pend || r);
        chk("in_ready_a", int'(in_ready_a), int'(exp_ready));
        chk("in_ready_b", int'(in_ready_b), int'(exp_ready));
        chk("out_valid_a", int'(out_valid_a), int'(m_pend));
        chk("out_valid_b", int'(out_valid_b), int'(m_pend));
        if (rs) begin
            m_open = 1'b0; m_acc = 8'h00; m_n = 0; m_pend = 1'b0;
            q_a.delete(); q_b.delete();
        end else begin
            if (m_pend && r) m_pend = 1'b0;
            if (v && exp_ready) begin
                if (!m_open) begin m_acc = 8'h00; m_n = 0; end
                m_acc = m_acc ^ d;
                m_n++;
                if (l) begin
                    p.d = m_acc; p.n = m_n;
                    q_a.push_back(p); q_b.push_back(p);
                    m_pend = 1'b1; m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end else if (a) begin
                m_open = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: while a result is shown it must match the queue head; it retires on out_ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid_a) begin
                    if (q_a.size() == 0) begin
                        chk("unexpected_out_a", 1, 0);
                    end else begin
                        $display("result a: data=%02h count=%0d sat=%0d", out_data_a, out_count_a, out_sat_a);
                        chk("out_data_a", int'(out_data_a), int'(q_a[0].d));
                        chk("out_count_a", int'(out_count_a), satc(q_a[0].n, 255));
                        chk("out_sat_a", int'(out_sat_a), int'(q_a[0].n >= 255));
                        if (out_ready) void'(q_a.pop_front());
                    end
                end
                if (out_valid_b) begin
                    if (q_b.size() == 0) begin
                        chk("unexpected_out_b", 1, 0);
                    end else begin
                        $display("result b: data=%02h count=%0d sat=%0d", out_data_b, out_count_b, out_sat_b);
                        chk("out_data_b", int'(out_data_b), int'(q_b[0].d));
                        chk("out_count_b", int'(out_count_b), satc(q_b[0].n, 3));
                        chk("out_sat_b", int'(out_sat_b), int'(q_b[0].n >= 3));
                        if (out_ready) void'(q_b.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data", int'(out_data_a), 0);
        chk("rst_out_count", int'(out_count_a), 0);
        chk("rst_out_sat", int'(out_sat_a), 0);
        chk("rst_out_count_b", int'(out_count_b), 0);
        @(posedge clk);
        #1;
        step(0, 8'h00, 0, 0, 1, 0);

        // Three-beat packet: 5A ^ 3C ^ FF = 99
        step(1, 8'h5A, 0, 0, 1, 0);
        step(1, 8'h3C, 0, 0, 1, 0);
        step(1, 8'hFF, 1, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1, 0);

        // Held result under backpressure, then back-to-back handoff.
        step(1, 8'hA5, 1, 0, 0, 0);
        repeat (4) step(1, 8'h0F, 1, 0, 0, 0);
        step(1, 8'h0F, 1, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1, 0);

        // Abort drops the open packet and the beat offered with it.
        step(1, 8'h11, 0, 0, 1, 0);
        step(1, 8'h22, 0, 0, 1, 0);
        step(1, 8'h44, 0, 1, 1, 0);
        step(1, 8'h80, 1, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1, 0);

        // Five beats: CW=2 saturates at 3.
        repeat (4) step(1, 8'h01, 0, 0, 1, 0);
        step(1, 8'h01, 1, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1, 0);

        // Reset while a result is pending drops it.
        step(1, 8'h33, 1, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 1);
        step(1, 8'h07, 1, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1, 0);

        // Randomized traffic, including long packets to exercise CW=8 saturation.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 149) == 0);
        end
        for (int i = 0; i < 300; i++) begin
            step(1, 8'($urandom), i == 299, 0, 1, 0);
        end
        repeat (3) step(0, 8'h00, 0, 0, 1, 0);

        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
